// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 4-digit common-anode 7-segment scan sequencer with tear-free value commit.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits 3..1).
module seg_scan_controller #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        value_valid,
   output logic        value_ready,
   input  logic [3:0]  blank_mask,
   output logic [1:0]  digit_sel,
   output logic [3:0]  anode,
   output logic [3:0]  nibble,
   output logic        dp_n,
   output logic        frame_tick
);
   localparam int PW = $clog2(REFRESH_DIV);
   logic [PW-1:0] presc;
   logic [15:0]   pending, display;
   logic [3:0]    pending_dp, dp_display, lz;
   logic          pending_full, tc, wrap, xfer, off;
   assign tc          = presc == PW'(REFRESH_DIV - 1);
   assign wrap        = tc && digit_sel == 2'd3;
   assign value_ready = !pending_full;
   assign xfer        = value_valid && value_ready;
`ifdef LEADING_ZERO_BLANK_EN
   logic z3, z2, z1;
   assign z3 = display[15:12] == 4'd0;
   assign z2 = z3 && display[11:8] == 4'd0;
   assign z1 = z2 && display[7:4] == 4'd0;
   assign lz = {z3 && !dp_display[3], z2 && !dp_display[2], z1 && !dp_display[1], 1'b0};
`else
   assign lz = 4'b0000;
`endif
   assign off = blank_mask[digit_sel] | lz[digit_sel];
   // Prescaler sets the per-digit slot length
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) presc <= '0;
      else presc <= tc ? '0 : presc + PW'(1);
   // Digit index advances each slot; frame_tick marks the cycle after the 3->0 wrap
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         digit_sel  <= 2'd0;
         frame_tick <= 1'b0;
      end else begin
         digit_sel  <= tc ? digit_sel + 2'd1 : digit_sel;
         frame_tick <= wrap;
      end
   // Handshake into the pending buffer; pending moves to the display only at frame wrap
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pending      <= '0;
         pending_dp   <= '0;
         pending_full <= 1'b0;
         display      <= '0;
         dp_display   <= '0;
      end else begin
         if (xfer) begin
            pending    <= value_in;
            pending_dp <= dp_in;
         end
         if (wrap && pending_full) begin
            display    <= pending;
            dp_display <= pending_dp;
         end
         pending_full <= xfer ? 1'b1 : (wrap ? 1'b0 : pending_full);
      end
   // Pin registers follow digit_sel one cycle later; blanking is re-evaluated every cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         anode  <= 4'b1111;
         nibble <= 4'd0;
         dp_n   <= 1'b1;
      end else begin
         anode  <= off ? 4'b1111 : ~(4'b0001 << digit_sel);
         nibble <= display[{digit_sel, 2'b00} +: 4];
         dp_n   <= off | ~dp_display[digit_sel];
      end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed checks of scan timing, handshake commit, blanking and reset.
module tb_seg_scan_controller;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0, blank_mask = '0;
   logic        value_valid = 1'b0;
   logic        value_ready, dp_n, frame_tick;
   logic [1:0]  digit_sel;
   logic [3:0]  anode, nibble;
   int checks = 0, errors = 0, k = 0;
   typedef struct {
      int         k;
      logic [3:0] blank;
      logic [3:0] anode;
      logic [1:0] sel;
      logic       tick;
   } vec_t;
   vec_t tbl [18];
   localparam logic LZB =
`ifdef LEADING_ZERO_BLANK_EN
      1'b1;
`else
      1'b0;
`endif
   seg_scan_controller #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in),
      .value_valid(value_valid), .value_ready(value_ready), .blank_mask(blank_mask),
      .digit_sel(digit_sel), .anode(anode), .nibble(nibble), .dp_n(dp_n), .frame_tick(frame_tick)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got %h expected %h", name, k, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      k++;
      check("one_anode_low", 16'($countones(~anode) <= 1), 16'd1);
   endtask
   task automatic goto(input int t);
      while (k < t) tick();
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      value_valid = 1'b0;
      value_in = '0;
      dp_in = '0;
      blank_mask = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
   endtask
   task automatic send(input logic [15:0] v, input logic [3:0] d);
      value_in = v;
      dp_in = d;
      value_valid = 1'b1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog k=%0d got timeout expected finish", k);
      $fatal(1, "watchdog");
   end
   initial begin
      tbl = '{
         '{0,  4'b0000, 4'b1111, 2'd0, 1'b0},
         '{1,  4'b0000, 4'b1110, 2'd0, 1'b0},
         '{4,  4'b0000, 4'b1110, 2'd1, 1'b0},
         '{5,  4'b0000, 4'b1101, 2'd1, 1'b0},
         '{8,  4'b0000, 4'b1101, 2'd2, 1'b0},
         '{9,  4'b0000, 4'b1011, 2'd2, 1'b0},
         '{12, 4'b0000, 4'b1011, 2'd3, 1'b0},
         '{13, 4'b0000, 4'b0111, 2'd3, 1'b0},
         '{16, 4'b0000, 4'b0111, 2'd0, 1'b1},
         '{17, 4'b0000, 4'b1110, 2'd0, 1'b0},
         '{25, 4'b0100, 4'b1111, 2'd2, 1'b0},
         '{26, 4'b0000, 4'b1011, 2'd2, 1'b0},
         '{27, 4'b0100, 4'b1111, 2'd2, 1'b0},
         '{29, 4'b0100, 4'b0111, 2'd3, 1'b0},
         '{32, 4'b0001, 4'b0111, 2'd0, 1'b1},
         '{33, 4'b0001, 4'b1111, 2'd0, 1'b0},
         '{34, 4'b0000, 4'b1110, 2'd0, 1'b0},
         '{48, 4'b0000, 4'b0111, 2'd0, 1'b1}
      };
      do_reset();
      check("rst_anode", 16'(anode), 16'b1111);
      check("rst_sel", 16'(digit_sel), 16'd0);
      check("rst_nibble", 16'(nibble), 16'd0);
      check("rst_dp_n", 16'(dp_n), 16'd1);
      check("rst_tick", 16'(frame_tick), 16'd0);
      check("rst_ready", 16'(value_ready), 16'd1);
      foreach (tbl[i]) begin
         blank_mask = tbl[i].blank;
         goto(tbl[i].k);
         check("tbl_anode", 16'(anode), 16'(tbl[i].anode));
         check("tbl_sel", 16'(digit_sel), 16'(tbl[i].sel));
         check("tbl_tick", 16'(frame_tick), 16'(tbl[i].tick));
      end
      // 1234 mid-frame, ABCD held while pending full
      do_reset();
      goto(2);
      check("b_ready_idle", 16'(value_ready), 16'd1);
      send(16'h1234, 4'b0101);
      tick();
      check("b_ready_full", 16'(value_ready), 16'd0);
      send(16'hABCD, 4'b0000);
      goto(15);
      check("b_ready_wait", 16'(value_ready), 16'd0);
      check("b_nib_old", 16'(nibble), 16'h0);
      goto(16);
      check("b_ready_commit", 16'(value_ready), 16'd1);
      tick();
      value_valid = 1'b0;
      check("b_ready_abcd", 16'(value_ready), 16'd0);
      check("b_nib0", 16'(nibble), 16'h4);
      check("b_dp0", 16'(dp_n), 16'd0);
      goto(21);
      check("b_nib1", 16'(nibble), 16'h3);
      check("b_dp1", 16'(dp_n), 16'd1);
      goto(25);
      check("b_nib2", 16'(nibble), 16'h2);
      check("b_dp2", 16'(dp_n), 16'd0);
      goto(29);
      check("b_nib3", 16'(nibble), 16'h1);
      goto(32);
      check("b_ready_free", 16'(value_ready), 16'd1);
      goto(33);
      check("b_nibD", 16'(nibble), 16'hD);
      check("b_dpD", 16'(dp_n), 16'd1);
      goto(45);
      check("b_nibA", 16'(nibble), 16'hA);
      // asynchronous reset mid-frame with a pending value
      send(16'h5555, 4'b1111);
      goto(47);
      value_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_anode", 16'(anode), 16'b1111);
      check("ar_sel", 16'(digit_sel), 16'd0);
      check("ar_nibble", 16'(nibble), 16'h0);
      check("ar_dp_n", 16'(dp_n), 16'd1);
      check("ar_ready", 16'(value_ready), 16'd1);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      goto(17);
      check("ar_disp_clr", 16'(nibble), 16'h0);
      check("ar_anode0", 16'(anode), 16'b1110);
      goto(33);
      check("ar_pend_gone", 16'(nibble), 16'h0);
      // 5678 valid on the wrap edge while 1111 pending
      do_reset();
      goto(2);
      send(16'h1111, 4'b0000);
      tick();
      value_valid = 1'b0;
      goto(15);
      send(16'h5678, 4'b0000);
      tick();
      check("c_ready_wrap", 16'(value_ready), 16'd1);
      tick();
      value_valid = 1'b0;
      check("c_ready_cap", 16'(value_ready), 16'd0);
      check("c_nib_1111", 16'(nibble), 16'h1);
      goto(29);
      check("c_nib_1111_d3", 16'(nibble), 16'h1);
      goto(33);
      check("c_nib8", 16'(nibble), 16'h8);
      goto(45);
      check("c_nib5", 16'(nibble), 16'h5);
      // capture on the wrap edge with pending empty commits one frame later
      do_reset();
      goto(15);
      send(16'h9ABC, 4'b0000);
      tick();
      value_valid = 1'b0;
      check("d_ready_cap", 16'(value_ready), 16'd0);
      tick();
      check("d_no_commit", 16'(nibble), 16'h0);
      goto(32);
      check("d_ready_free", 16'(value_ready), 16'd1);
      goto(33);
      check("d_nibC", 16'(nibble), 16'hC);
      goto(37);
      check("d_nibB", 16'(nibble), 16'hB);
      // blanking forces dp_n high on a lit decimal point
      do_reset();
      goto(2);
      send(16'h4321, 4'b0100);
      tick();
      value_valid = 1'b0;
      goto(20);
      blank_mask = 4'b0100;
      goto(25);
      check("e_blank_anode", 16'(anode), 16'b1111);
      check("e_blank_dp", 16'(dp_n), 16'd1);
      blank_mask = 4'b0000;
      tick();
      check("e_show_anode", 16'(anode), 16'b1011);
      check("e_show_dp", 16'(dp_n), 16'd0);
      check("e_show_nib", 16'(nibble), 16'h3);
      blank_mask = 4'b0100;
      goto(29);
      check("e_d3_anode", 16'(anode), 16'b0111);
      check("e_d3_nib", 16'(nibble), 16'h4);
      // leading zero handling for 0070
      do_reset();
      goto(2);
      send(16'h0070, 4'b0000);
      tick();
      value_valid = 1'b0;
      goto(17);
      check("f_d0_anode", 16'(anode), 16'b1110);
      check("f_d0_nib", 16'(nibble), 16'h0);
      goto(21);
      check("f_d1_anode", 16'(anode), 16'b1101);
      check("f_d1_nib", 16'(nibble), 16'h7);
      goto(25);
      check("f_d2_anode", 16'(anode), LZB ? 16'b1111 : 16'b1011);
      goto(29);
      check("f_d3_anode", 16'(anode), LZB ? 16'b1111 : 16'b0111);
      check("f_d3_dp", 16'(dp_n), 16'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
